fetch_stage: RTL and testbench
==============================

# fetch_stage

Front-end fetch stage of the superscalar LEGv8 core, upstream of the instruction ROM and downstream-facing to decode. It generates a two-wide PC stream (pc, pc+4), issues read requests to the 1-cycle-latency instruction ROM, and captures the returned instruction pairs into a small queue. Decode drains the queue through a valid/ready handshake. A redirect port from branch resolution flushes the queue and restarts fetch at a new PC.

## Interface
- XLEN, 32, data/address width
- FQ_DEPTH, 4, fetch-queue depth in instruction pairs; power of two, ≥2
- RESET_PC, 32'h0, first fetch address after reset
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- imem_ren  out  1  ROM read request
- imem_addr0  out  XLEN  slot-0 fetch address (= fetch PC)
- imem_addr1  out  XLEN  slot-1 fetch address (= fetch PC + 4)
- imem_valid  in  1  ROM response valid
- imem_rdata0 / imem_rdata1  in  XLEN each  returned instructions
- imem_pc  in  2×XLEN  PCs echoed with the response
- redirect_valid  in  1  flush and restart request
- redirect_pc  in  XLEN  restart address; bits [1:0] ignored (forced 0)
- dec_valid  out  1  queue head valid
- dec_ready  in  1  decode accepts head
- dec_instr  out  2×XLEN  head instructions [0], [1]
- dec_pc  out  2×XLEN  head PCs [0], [1]
- fq_count  out  $clog2(FQ_DEPTH)+1  current occupancy

## Operation
- Registered state: fetch_pc, inflight flag, queue (head, tail, count).
- Issue rule, normal cycle: imem_ren = (count + inflight < FQ_DEPTH). Addresses are fetch_pc and fetch_pc+4. On issue, fetch_pc += 8 and inflight <= 1; otherwise inflight <= 0.
- Issue rule, redirect cycle: imem_ren = 1, addresses are {redirect_pc[XLEN-1:2],2'b00} and +4, fetch_pc <= that value + 8, inflight <= 1.
- Capture: a response is pushed only when inflight==1 and imem_valid==1 and redirect_valid==0. imem_valid alone is never trusted, because the ROM holds it high after the last request. inflight==1 with imem_valid==0 is dropped.
- Pushed entry stores {imem_rdata0, imem_rdata1, imem_pc[0], imem_pc[1]}.
- Pop: dec_valid && dec_ready. dec_valid = (count != 0) && !redirect_valid.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Overflow: the issue rule makes it impossible. An assertion fires if a push occurs while count == FQ_DEPTH.
- Redirect: count, head and tail are cleared. The in-flight response is discarded, and any pop in that cycle is suppressed.
- Pointer and PC arithmetic wraps modulo 2^width with no error.

## Timing
- Reset (reset==0): fetch_pc=RESET_PC, inflight=0, count=0, head=tail=0. Outputs: imem_ren=0, dec_valid=0, fq_count=0; data outputs are don't-care.
- First cycle after reset release: imem_ren=1 at RESET_PC.
- Fetch-to-queue latency is 2 edges: ren in cycle N, data visible in N+1, captured at end of N+1, dec_valid in N+2.
- With dec_ready held high, steady-state throughput is one pair per cycle.
- Redirect in cycle R: new request in R, first new pair on dec_valid in R+2.
- Reset asserted mid-operation clears all state asynchronously. No response is captured until a new issue.

## Structure
- core_pkg gets the fetch_pair_t struct {instr[2], pc[2]} and the FETCH_WIDTH=2 constant.
- Sub-module fetch_queue: synchronous FIFO of fetch_pair_t with flush, push, pop and count. fetch_stage holds the PC/issue/inflight logic.

## Test plan
- Reset release, dec_ready=1, ROM model preloaded → addrs 0/4, 8/12, 16/20…; dec_pc pairs (0,4), (8,12) arrive on consecutive cycles from cycle 2.
- dec_ready=0 → fq_count saturates at 4; imem_ren drops to 0; no overflow. Then dec_ready=1 → pairs drain in order with no duplicates or skips.
- ROM imem_valid stuck high, stall for 10 cycles → no spurious pushes (count stays at 4).
- redirect_valid with redirect_pc=0x103 while queue holds 3 entries → count goes to 0, imem_addr0=0x100 in the same cycle, next dec_pc=(0x100,0x104); the old in-flight pair is never seen.
- Redirect coincident with a dec_ready pop and an inbound response → no pop and no push; count=0 next cycle.
- Assert reset during streaming → all outputs reach reset values immediately; after release, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: fetch width, XLEN and the fetch-pair bundle
// passed from fetch to decode.
package core_pkg;
  localparam int XLEN = 32;
  localparam int FETCH_WIDTH = 2;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t [FETCH_WIDTH-1:0] instr;
    word_t [FETCH_WIDTH-1:0] pc;
  } fetch_pair_t;
endpackage

// File: rtl/fetch_stage_if.sv
// imem_if: fetch <-> instruction ROM request/response bus.
// dec_if:  fetch -> decode valid/ready pair bundle.
interface imem_if import core_pkg::*; ;
  logic  ren;
  word_t addr0;
  word_t addr1;
  logic  valid;
  word_t rdata0;
  word_t rdata1;
  word_t [FETCH_WIDTH-1:0] pc;

  modport master (
    output ren, addr0, addr1,
    input  valid, rdata0, rdata1, pc
  );
  modport slave (
    input  ren, addr0, addr1,
    output valid, rdata0, rdata1, pc
  );
endinterface

interface dec_if import core_pkg::*; ;
  logic  valid;
  logic  ready;
  word_t [FETCH_WIDTH-1:0] instr;
  word_t [FETCH_WIDTH-1:0] pc;

  modport master (
    output valid, instr, pc,
    input  ready
  );
  modport slave (
    input  valid, instr, pc,
    output ready
  );
endinterface

// File: rtl/fetch_stage_queue.sv
// fetch_queue: synchronous FIFO of fetch_pair_t with flush.
// Ports: flush/push/pop controls, push_data in, head_data/count out.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_pair_t   push_data,
  input  logic          pop,
  output fetch_pair_t   head_data,
  output logic [CW-1:0] count
);
  fetch_pair_t   mem_q [DEPTH];
  fetch_pair_t   mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

  // The issue throttle should make a push into a full queue impossible.
  always @(posedge clk) begin
    if (rst_n && push && !flush)
      assert (count_q != CW'(DEPTH));
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: two-wide PC generator, ROM issue and fetch queue.
// Ports: clk, reset (async low), imem bus, redirect, dec bus, fq_count.
module fetch_stage
  import core_pkg::*;
#(
  parameter int    FQ_DEPTH = 4,
  parameter word_t RESET_PC = '0,
  localparam int   CW = $clog2(FQ_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  imem_if.master        imem,
  input  logic          redirect_valid,
  input  word_t         redirect_pc,
  dec_if.master         dec,
  output logic [CW-1:0] fq_count
);
  word_t       fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  word_t       base;
  logic        issue;
  logic        issue_ok;
  logic [CW:0] occ;
  logic        push;
  logic        pop;
  fetch_pair_t push_data;
  fetch_pair_t head_data;

  // Count the outstanding request so a full queue never overflows.
  assign occ = {1'b0, fq_count} + {{CW{1'b0}}, inflight_q};
  assign issue_ok = occ < (CW+1)'(FQ_DEPTH);

  always_comb begin
    base       = fetch_pc_q;
    issue      = issue_ok;
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    if (redirect_valid) begin
      base  = {redirect_pc[XLEN-1:2], 2'b00};
      issue = 1'b1;
    end
    if (issue) begin
      fetch_pc_d = base + XLEN'(8);
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign imem.ren   = issue & reset;
  assign imem.addr0 = base;
  assign imem.addr1 = base + XLEN'(4);

  // ROM valid is sticky; only a response we asked for is captured.
  assign push = inflight_q & imem.valid & ~redirect_valid;
  assign push_data.instr = {imem.rdata1, imem.rdata0};
  assign push_data.pc    = imem.pc;

  assign dec.valid = (fq_count != '0) & ~redirect_valid;
  assign pop       = dec.valid & dec.ready;
  assign dec.instr = head_data.instr;
  assign dec.pc    = head_data.pc;

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fq_count)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a sticky-valid
// 1-cycle ROM model.
module tb_fetch_stage;
  import core_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       redirect_valid;
  word_t      redirect_pc;
  logic [2:0] fq_count;

  imem_if im ();
  dec_if  dc ();

  fetch_stage #(.FQ_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (im),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dc),
    .fq_count       (fq_count)
  );

  always #5 clk = ~clk;

  function automatic word_t instr_of(word_t pc);
    return pc ^ 32'h8B00_0000;
  endfunction

  // ROM: valid stays high once any request has been served.
  logic  rom_valid = 1'b0;
  word_t rom_d0 = '0;
  word_t rom_d1 = '0;
  word_t rom_p0 = '0;
  word_t rom_p1 = '0;
  always @(posedge clk) begin
    if (im.ren) begin
      rom_valid <= 1'b1;
      rom_d0 <= instr_of(im.addr0);
      rom_d1 <= instr_of(im.addr1);
      rom_p0 <= im.addr0;
      rom_p1 <= im.addr1;
    end
  end
  assign im.valid  = rom_valid;
  assign im.rdata0 = rom_d0;
  assign im.rdata1 = rom_d1;
  assign im.pc     = {rom_p1, rom_p0};

  typedef struct {
    logic  rst;
    logic  rdy;
    logic  rv;
    word_t rpc;
    logic  ren;
    logic  ca;
    word_t addr;
    logic  dv;
    word_t pc0;
    int    fq;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(
    logic rst, logic rdy, logic rv, word_t rpc,
    logic ren, logic ca, word_t addr,
    logic dv, word_t pc0, int fq);
    vq.push_back('{rst, rdy, rv, rpc, ren, ca, addr, dv, pc0, fq});
  endfunction

  task automatic chk(string nm, int row, word_t act, word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    dc.ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #2 reset = 1'b0;

    // in reset
    add(0,1,0,0,     0,0,0,     0,0,0);
    // release, stream with ready high
    add(1,1,0,0,     1,1,'h00,  0,0,0);
    add(1,1,0,0,     1,1,'h08,  0,0,0);
    add(1,1,0,0,     1,1,'h10,  1,'h00,1);
    add(1,1,0,0,     1,1,'h18,  1,'h08,1);
    add(1,1,0,0,     1,1,'h20,  1,'h10,1);
    // decode stalls: fill to 4, issue stops
    add(1,0,0,0,     1,1,'h28,  1,'h18,1);
    add(1,0,0,0,     1,1,'h30,  1,'h18,2);
    add(1,0,0,0,     0,1,'h38,  1,'h18,3);
    for (int i = 0; i < 10; i++)
      add(1,0,0,0,   0,1,'h38,  1,'h18,4);
    // drain in order
    add(1,1,0,0,     0,1,'h38,  1,'h18,4);
    add(1,1,0,0,     1,1,'h38,  1,'h20,3);
    add(1,1,0,0,     1,1,'h40,  1,'h28,2);
    add(1,1,0,0,     1,1,'h48,  1,'h30,2);
    add(1,0,0,0,     1,1,'h50,  1,'h38,2);
    // redirect with 3 queued, unaligned target
    add(1,0,1,'h103, 1,1,'h100, 0,0,3);
    add(1,0,0,0,     1,1,'h108, 0,0,0);
    add(1,0,0,0,     1,1,'h110, 1,'h100,1);
    // redirect with pop and inbound response
    add(1,1,1,'h200, 1,1,'h200, 0,0,2);
    add(1,1,0,0,     1,1,'h208, 0,0,0);
    add(1,1,0,0,     1,1,'h210, 1,'h200,1);
    // reset mid-stream, resume at RESET_PC
    add(0,1,0,0,     0,0,0,     0,0,0);
    add(1,1,0,0,     1,1,'h00,  0,0,0);
    add(1,1,0,0,     1,1,'h08,  0,0,0);
    add(1,1,0,0,     1,1,'h10,  1,'h00,1);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset          = vq[i].rst;
      dc.ready       = vq[i].rdy;
      redirect_valid = vq[i].rv;
      redirect_pc    = vq[i].rpc;
      #1;
      chk("ren", i, 32'(im.ren), 32'(vq[i].ren));
      if (vq[i].ca) begin
        chk("addr0", i, im.addr0, vq[i].addr);
        chk("addr1", i, im.addr1, vq[i].addr + 4);
      end
      chk("dec_valid", i, 32'(dc.valid), 32'(vq[i].dv));
      if (vq[i].dv) begin
        chk("dec_pc0", i, dc.pc[0], vq[i].pc0);
        chk("dec_pc1", i, dc.pc[1], vq[i].pc0 + 4);
        chk("instr0", i, dc.instr[0], instr_of(vq[i].pc0));
        chk("instr1", i, dc.instr[1], instr_of(vq[i].pc0 + 4));
      end
      chk("fq_count", i, 32'(fq_count), 32'(vq[i].fq));
    end

    // steady state: one new pair per cycle, no skips or repeats
    begin
      word_t exp_pc = 32'h08;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        #1;
        chk("stream_valid", 100 + i, 32'(dc.valid), 32'd1);
        chk("stream_pc", 100 + i, dc.pc[0], exp_pc);
        exp_pc += 8;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
